// File: rtl/sub_clock_pkg.sv
// sub_clock_pkg
// Shared definitions for the run-time-programmable clock divider:
// channel state encoding and the default channel count / counter width.
package sub_clock_pkg;

    localparam int DEFAULT_WIDTH    = 26;
    localparam int DEFAULT_CHANNELS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } chan_state_e;

endpackage

// File: rtl/sub_clock_chan.sv
// sub_clock_chan
// One divider channel: a three-state FSM (IDLE/HIGH/LOW) with a half-period
// counter and a latched half-period. The half-period and the enable are only
// acted upon at a period boundary, so the output never carries a runt pulse.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   en       in   run request
//   halfper  in   requested half-period in clk cycles (0 = stop)
//   outclk   out  divided clock, registered
//   rise     out  one-cycle strobe in the first cycle of each high phase
//   busy     out  high while the channel is not idle
module sub_clock_chan
    import sub_clock_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] halfper,
    output logic             outclk,
    output logic             rise,
    output logic             busy
);

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    chan_state_e      state_r;
    chan_state_e      state_s;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] cnt_s;
    logic [WIDTH-1:0] hp_r;
    logic [WIDTH-1:0] hp_s;
    logic             outclk_r;
    logic             outclk_s;
    logic             rise_r;
    logic             rise_s;
    logic             busy_r;
    logic             busy_s;

    logic             start_ok_s;
    logic             last_s;

    // A new period may begin only when requested with a usable half-period.
    assign start_ok_s = en && (halfper != CNT_ZERO);
    // Final cycle of the current phase; meaningless (and unused) while idle.
    assign last_s     = (cnt_r == (hp_r - CNT_ONE));

    // State, counter, half-period and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= CNT_ZERO;
            hp_r     <= CNT_ZERO;
            outclk_r <= 1'b0;
            rise_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            hp_r     <= hp_s;
            outclk_r <= outclk_s;
            rise_r   <= rise_s;
            busy_r   <= busy_s;
        end
    end

    // Next-state, counter and half-period latch decisions.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        hp_s    = hp_r;
        case (state_r)
            ST_IDLE: begin
                cnt_s = CNT_ZERO;
                if (start_ok_s) begin
                    hp_s    = halfper;
                    state_s = ST_HIGH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HIGH: begin
                if (last_s) begin
                    cnt_s   = CNT_ZERO;
                    state_s = ST_LOW;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_LOW: begin
                if (last_s) begin
                    cnt_s = CNT_ZERO;
                    // Period boundary: back-to-back restart or drop to idle.
                    if (start_ok_s) begin
                        hp_s    = halfper;
                        state_s = ST_HIGH;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Output values for the state being entered, so the registers line up
    // with the state register and no input reaches an output combinationally.
    always_comb begin
        outclk_s = (state_s == ST_HIGH);
        busy_s   = (state_s != ST_IDLE);
        rise_s   = (state_s == ST_HIGH) && (state_r != ST_HIGH);
    end

    assign outclk = outclk_r;
    assign rise   = rise_r;
    assign busy   = busy_r;

endmodule

// File: rtl/sub_clock_dyn_multi.sv
// sub_clock_dyn_multi
// Multi-channel run-time-programmable clock divider. Each channel is an
// independent sub_clock_chan; HALFPER is sliced WIDTH bits per channel.
//
// Ports:
//   CLK      in   system clock, rising edge
//   RST      in   asynchronous active-high reset
//   EN       in   per-channel run request            [CHANNELS]
//   HALFPER  in   per-channel half-period, ch i at [i*WIDTH +: WIDTH]
//   OUTCLK   out  divided clocks, registered         [CHANNELS]
//   RISE     out  first-high-cycle strobes           [CHANNELS]
//   BUSY     out  channel-not-idle flags             [CHANNELS]
module sub_clock_dyn_multi
    import sub_clock_pkg::*;
#(
    parameter int CHANNELS = DEFAULT_CHANNELS,
    parameter int WIDTH    = DEFAULT_WIDTH
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [CHANNELS-1:0]       EN,
    input  logic [CHANNELS*WIDTH-1:0] HALFPER,
    output logic [CHANNELS-1:0]       OUTCLK,
    output logic [CHANNELS-1:0]       RISE,
    output logic [CHANNELS-1:0]       BUSY
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        sub_clock_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk     (CLK),
            .rst     (RST),
            .en      (EN[g]),
            .halfper (HALFPER[g*WIDTH +: WIDTH]),
            .outclk  (OUTCLK[g]),
            .rise    (RISE[g]),
            .busy    (BUSY[g])
        );
    end

endmodule

// File: tb/tb_sub_clock_dyn_multi.sv
// tb_sub_clock_dyn_multi
// Directed bench for sub_clock_dyn_multi: a table of per-cycle vectors for
// channel 0 (basic, retune, disable/restart, zero half-period) followed by
// hand-written sequences for hp=1, async reset, channel independence and a
// maximum half-period on a reduced-width instance.
module tb_sub_clock_dyn_multi;

    localparam int CH = 4;
    localparam int W  = 26;
    localparam int WS = 8;

    logic            CLK;
    logic            RST;
    logic [CH-1:0]   EN;
    logic [CH*W-1:0] HALFPER;
    logic [CH-1:0]   OUTCLK;
    logic [CH-1:0]   RISE;
    logic [CH-1:0]   BUSY;

    logic            en_s;
    logic [WS-1:0]   halfper_s;
    logic [0:0]      outclk_s;
    logic [0:0]      rise_s;
    logic [0:0]      busy_s;

    int errors = 0;
    int checks = 0;

    sub_clock_dyn_multi #(.CHANNELS(CH), .WIDTH(W)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .EN      (EN),
        .HALFPER (HALFPER),
        .OUTCLK  (OUTCLK),
        .RISE    (RISE),
        .BUSY    (BUSY)
    );

    sub_clock_dyn_multi #(.CHANNELS(1), .WIDTH(WS)) dut_small (
        .CLK     (CLK),
        .RST     (RST),
        .EN      (en_s),
        .HALFPER (halfper_s),
        .OUTCLK  (outclk_s),
        .RISE    (rise_s),
        .BUSY    (busy_s)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        en;
        logic [25:0] hp;
        logic        exp_o;
        logic        exp_r;
        logic        exp_b;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int idx, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %b expected %b", name, idx, got, exp);
        end
    endtask

    // Pushes n cycles of one phase; rise and reset apply to the first only.
    task automatic add(input logic rst, input logic en, input int hp,
                       input logic o, input logic r, input logic b, input int n);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.rst   = (i == 0) ? rst : 1'b0;
            v.en    = en;
            v.hp    = hp[25:0];
            v.exp_o = o;
            v.exp_r = (i == 0) ? r : 1'b0;
            v.exp_b = b;
            vecs.push_back(v);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Async reset pulse between edges; outputs must drop before any edge.
    task automatic do_reset(input string name);
        RST = 1'b1;
        #1;
        chk({name, "_outclk"}, 0, OUTCLK, 4'b0000);
        chk({name, "_rise"},   0, RISE,   4'b0000);
        chk({name, "_busy"},   0, BUSY,   4'b0000);
        #1;
        RST = 1'b0;
    endtask

    // Closed-form expectation for a free-running channel: {busy, rise, out}.
    function automatic logic [2:0] expect_ch(input int hp, input int m);
        int p;
        if (hp == 0) return 3'b000;
        p = m % (2 * hp);
        return {1'b1, (p == 0), (p < hp)};
    endfunction

    initial begin
        logic [2:0] e0, e1, e2, e3;

        RST = 1'b1; EN = '0; HALFPER = '0; en_s = 1'b0; halfper_s = '0;

        // Basic hp=3: high 3, low 3, repeating.
        add(1'b1, 1'b1, 3, 1'b1, 1'b1, 1'b1, 3);
        add(1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b1, 3);
        add(1'b0, 1'b1, 3, 1'b1, 1'b1, 1'b1, 3);
        add(1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b1, 3);
        add(1'b0, 1'b1, 3, 1'b1, 1'b1, 1'b1, 2);
        // Retune 3->5 inside the first high phase: 3/3 then 5/5.
        add(1'b1, 1'b1, 3, 1'b1, 1'b1, 1'b1, 1);
        add(1'b0, 1'b1, 5, 1'b1, 1'b0, 1'b1, 2);
        add(1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b1, 3);
        add(1'b0, 1'b1, 5, 1'b1, 1'b1, 1'b1, 5);
        add(1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b1, 5);
        add(1'b0, 1'b1, 5, 1'b1, 1'b1, 1'b1, 1);
        // Disable in 2nd high cycle (hp=4): full period, one idle, restart.
        add(1'b1, 1'b1, 4, 1'b1, 1'b1, 1'b1, 1);
        add(1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b1, 3);
        add(1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b1, 4);
        add(1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0, 1);
        add(1'b0, 1'b1, 4, 1'b1, 1'b1, 1'b1, 1);
        add(1'b0, 1'b1, 4, 1'b1, 1'b0, 1'b1, 1);
        // HALFPER=0 with EN=1 stays idle; EN=0 also idle.
        add(1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 3);
        add(1'b0, 1'b0, 6, 1'b0, 1'b0, 1'b0, 2);

        #12;
        chk("reset_outclk", 0, OUTCLK, 4'b0000);
        chk("reset_rise",   0, RISE,   4'b0000);
        chk("reset_busy",   0, BUSY,   4'b0000);
        chk("reset_small",  0, {1'b0, busy_s, rise_s, outclk_s}, 4'b0000);
        step();
        RST = 1'b0;

        // Table-driven section (channel 0, others idle).
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset("tbl_rst");
            EN      = {3'b000, vecs[i].en};
            HALFPER = {78'd0, vecs[i].hp};
            step();
            chk("tbl_outclk", i, OUTCLK, {3'b000, vecs[i].exp_o});
            chk("tbl_rise",   i, RISE,   {3'b000, vecs[i].exp_r});
            chk("tbl_busy",   i, BUSY,   {3'b000, vecs[i].exp_b});
        end

        // hp=1: toggles every cycle, RISE every second cycle.
        do_reset("hp1_rst");
        EN = 4'b0001; HALFPER = {78'd0, 26'd1};
        for (int n = 0; n < 10; n++) begin
            step();
            chk("hp1_outclk", n, OUTCLK, {3'b000, (n % 2 == 0)});
            chk("hp1_rise",   n, RISE,   {3'b000, (n % 2 == 0)});
            chk("hp1_busy",   n, BUSY,   4'b0001);
        end

        // Async reset in the first high cycle, then full-length restart.
        do_reset("ar_pre");
        EN = 4'b0001; HALFPER = {78'd0, 26'd4};
        step();
        chk("ar_started", 0, {1'b0, BUSY[0], RISE[0], OUTCLK[0]}, 4'b0111);
        do_reset("ar_mid");
        for (int n = 0; n < 10; n++) begin
            step();
            chk("ar_outclk", n, OUTCLK, {3'b000, (n < 4) || (n >= 8)});
            chk("ar_rise",   n, RISE,   {3'b000, (n == 0) || (n == 8)});
            chk("ar_busy",   n, BUSY,   4'b0001);
        end

        // Independence: hp 2/7/0/1; ch1 EN dropped then re-raised.
        EN = 4'b0000;
        do_reset("ind_rst");
        HALFPER = {26'd1, 26'd0, 26'd7, 26'd2};
        EN = 4'b1111;
        for (int n = 0; n < 60; n++) begin
            if (n == 16) EN[1] = 1'b0;
            if (n == 30) EN[1] = 1'b1;
            step();
            e0 = expect_ch(2, n);
            e2 = expect_ch(0, n);
            e3 = expect_ch(1, n);
            if (n < 28)      e1 = expect_ch(7, n);
            else if (n < 30) e1 = 3'b000;
            else             e1 = expect_ch(7, n - 30);
            chk("ind_outclk", n, OUTCLK, {e3[0], e2[0], e1[0], e0[0]});
            chk("ind_rise",   n, RISE,   {e3[1], e2[1], e1[1], e0[1]});
            chk("ind_busy",   n, BUSY,   {e3[2], e2[2], e1[2], e0[2]});
        end

        // Maximum half-period on the reduced-width instance: 2^8-1.
        EN = 4'b0000;
        do_reset("max_rst");
        en_s = 1'b1; halfper_s = 8'hFF;
        for (int n = 0; n < 520; n++) begin
            step();
            e0 = expect_ch(255, n);
            chk("max_chan", n, {1'b0, busy_s, rise_s, outclk_s}, {1'b0, e0});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
